// File: rtl/reg_bank_if.sv
// Bus-side signal bundle for reg_bank. The dec line exists only when REG_BANK_DEC_EN is defined.
interface reg_bank_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  // Command semantics: load/inc/dec are level commands sampled on every rising
  // edge; there is no valid/ready pair because the bank always accepts at once.
  logic [WIDTH-1:0]  bus;
  logic [ADDR_W-1:0] wr_sel;
  logic [ADDR_W-1:0] rd_sel;
  logic              load;
  logic              inc;
`ifdef REG_BANK_DEC_EN
  logic              dec;
`endif
  logic              enable;
  logic              carry;
  logic              zero;
  logic              bus_oe;

`ifdef REG_BANK_DEC_EN
  modport master (
    output bus, wr_sel, rd_sel, load, inc, dec, enable,
    input  carry, zero, bus_oe
  );
  modport slave (
    input  bus, wr_sel, rd_sel, load, inc, dec, enable,
    output carry, zero, bus_oe
  );
`else
  modport master (
    output bus, wr_sel, rd_sel, load, inc, enable,
    input  carry, zero, bus_oe
  );
  modport slave (
    input  bus, wr_sel, rd_sel, load, inc, enable,
    output carry, zero, bus_oe
  );
`endif
endinterface

// File: rtl/reg_bank.sv
// Bank of NUM_REGS bus registers with load, in-place increment and a tri-state read driver.
// Optional decrement path enabled by defining REG_BANK_DEC_EN.
module reg_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  reg_bank_if.slave        s,
  output logic [WIDTH-1:0] bus_out
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_carry;

  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] w_wr_cur;
  logic             w_wr_valid;
  logic [WIDTH-1:0] w_next;
  logic             w_we;
  logic             w_carry_we;
  logic             w_carry_next;
  logic             w_oe;

  // Out-of-range read selects fall through to zero data.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s.rd_sel == ADDR_W'(i)) w_rd_data = r_regs[i];
    end
  end

  always_comb begin
    w_wr_cur   = '0;
    w_wr_valid = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s.wr_sel == ADDR_W'(i)) begin
        w_wr_cur   = r_regs[i];
        w_wr_valid = 1'b1;
      end
    end
  end

  // Priority load > inc > dec; carry only moves on arithmetic actions.
  always_comb begin
    w_next       = w_wr_cur;
    w_we         = 1'b0;
    w_carry_we   = 1'b0;
    w_carry_next = r_carry;
    if (w_wr_valid) begin
      if (s.load) begin
        w_next = s.bus;
        w_we   = 1'b1;
      end else if (s.inc) begin
        w_next       = w_wr_cur + WIDTH'(1);
        w_we         = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = &w_wr_cur;
      end
`ifdef REG_BANK_DEC_EN
      else if (s.dec) begin
        w_next       = w_wr_cur - WIDTH'(1);
        w_we         = 1'b1;
        w_carry_we   = 1'b1;
        w_carry_next = ~|w_wr_cur;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_carry <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we && (s.wr_sel == ADDR_W'(i))) r_regs[i] <= w_next;
      end
      if (w_carry_we) r_carry <= w_carry_next;
    end
  end

  // The driver is released while clear_n is low, whatever enable says.
  assign w_oe     = s.enable & clear_n;
  assign bus_out  = w_oe ? w_rd_data : {WIDTH{1'bz}};
  assign s.bus_oe = w_oe;
  assign s.carry  = r_carry;
  assign s.zero   = ~|w_rd_data;
endmodule

// File: tb/tb_reg_bank.sv
// Directed and randomized checks of reg_bank (NUM_REGS=3) against an array-based reference model.
module tb_reg_bank;
  localparam int WIDTH = 8;
  localparam int NREGS = 3;

  logic             clk = 1'b0;
  logic             clear_n;
  logic [WIDTH-1:0] bus_out;

  reg_bank_if #(.WIDTH(WIDTH), .NUM_REGS(NREGS)) intf ();

  reg_bank #(.WIDTH(WIDTH), .NUM_REGS(NREGS)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .s       (intf.slave),
    .bus_out (bus_out)
  );

  always #5 clk = ~clk;

  int m_regs [NREGS];
  bit m_carry;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_rd(input int rd);
    return (rd < NREGS) ? m_regs[rd] : 0;
  endfunction

  task automatic set_idle();
    intf.load   = 1'b0;
    intf.inc    = 1'b0;
`ifdef REG_BANK_DEC_EN
    intf.dec    = 1'b0;
`endif
    intf.enable = 1'b0;
    intf.bus    = '0;
    intf.wr_sel = '0;
    intf.rd_sel = '0;
  endtask

  // Advance the model with the inputs present at the coming edge, then pass the edge.
  task automatic do_cycle();
    int w;
    w = int'(intf.wr_sel);
    if (w < NREGS) begin
      if (intf.load) m_regs[w] = int'(intf.bus);
      else if (intf.inc) begin
        m_carry   = (m_regs[w] == 255);
        m_regs[w] = (m_regs[w] + 1) % 256;
      end
`ifdef REG_BANK_DEC_EN
      else if (intf.dec) begin
        m_carry   = (m_regs[w] == 0);
        m_regs[w] = (m_regs[w] + 255) % 256;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_read(input string tag, input int rd);
    intf.enable = 1'b1;
    intf.rd_sel = 2'(rd);
    #1;
    check({tag, "_oe"},   32'(intf.bus_oe), 32'd1);
    check({tag, "_data"}, 32'(bus_out),     32'(exp_rd(rd)));
    check({tag, "_zero"}, 32'(intf.zero),   32'(exp_rd(rd) == 0));
  endtask

  task automatic load_reg(input int r, input int v);
    set_idle();
    intf.load   = 1'b1;
    intf.wr_sel = 2'(r);
    intf.bus    = 8'(v);
    do_cycle();
    set_idle();
  endtask

  initial begin
    set_idle();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_carry = 1'b0;

    // Reset: driver released even with enable high
    clear_n     = 1'b0;
    intf.enable = 1'b1;
    #3;
    check("rst_oe",   32'(intf.bus_oe), 32'd0);
    check("rst_zero", 32'(intf.zero),   32'd1);
    @(negedge clk);
    clear_n = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) check_read($sformatf("rst_reg%0d", r), r);
    check("rst_carry", 32'(intf.carry), 32'(m_carry));

    // Load and read back
    load_reg(1, 8'hFE);
    load_reg(2, 8'h69);
    check_read("ld_reg1", 1);
    check_read("ld_reg2", 2);
    intf.enable = 1'b0;
    #1;
    check("ld_off_oe", 32'(intf.bus_oe), 32'd0);

    // Priority load over inc, no write-through
    load_reg(2, 8'h10);
    intf.load   = 1'b1;
    intf.inc    = 1'b1;
    intf.wr_sel = 2'd2;
    intf.bus    = 8'h55;
    check_read("prio_before", 2);
    do_cycle();
    check_read("prio_after", 2);
    check("prio_carry", 32'(intf.carry), 32'(m_carry));
    set_idle();

    // Wrap on increment
    load_reg(0, 8'hFF);
    intf.inc = 1'b1;
    do_cycle();
    set_idle();
    check_read("wrap_inc", 0);
    check("wrap_inc_carry", 32'(intf.carry), 32'd1);
    intf.inc = 1'b1;
    do_cycle();
    set_idle();
    check_read("wrap_inc2", 0);
    check("wrap_inc2_carry", 32'(intf.carry), 32'd0);
`ifdef REG_BANK_DEC_EN
    intf.dec = 1'b1;
    do_cycle();
    do_cycle();
    set_idle();
    check_read("wrap_dec", 0);
    check("wrap_dec_carry", 32'(intf.carry), 32'd1);
`endif

    // Async reset just before an edge carrying an inc
    load_reg(0, 8'hFF);
    intf.inc = 1'b1;
    do_cycle();
    set_idle();
    load_reg(2, 8'h69);
    intf.inc    = 1'b1;
    intf.wr_sel = 2'd2;
    intf.enable = 1'b1;
    intf.rd_sel = 2'd2;
    #6;
    clear_n = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_carry = 1'b0;
    #1;
    check("arst_oe",    32'(intf.bus_oe), 32'd0);
    check("arst_zero",  32'(intf.zero),   32'd1);
    check("arst_carry", 32'(intf.carry),  32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_zero",  32'(intf.zero),  32'd1);
    check("arst_hold_carry", 32'(intf.carry), 32'd0);
    set_idle();
    clear_n = 1'b1;
    #1;
    check_read("arst_reg2", 2);

    // Self-loop: bus fed from the driver output of the same register
    load_reg(1, 8'hA5);
    intf.enable = 1'b1;
    intf.rd_sel = 2'd1;
    intf.wr_sel = 2'd1;
    intf.load   = 1'b1;
    #1;
    intf.bus = bus_out;
    do_cycle();
    set_idle();
    check_read("selfloop", 1);

    // Out-of-range write and read
    intf.load   = 1'b1;
    intf.wr_sel = 2'd3;
    intf.bus    = 8'h77;
    do_cycle();
    set_idle();
    for (int r = 0; r < 4; r++) check_read($sformatf("oor_reg%0d", r), r);
    check("oor_carry", 32'(intf.carry), 32'(m_carry));

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      intf.load   = ($urandom_range(0, 3) == 0);
      intf.inc    = ($urandom_range(0, 2) == 0);
`ifdef REG_BANK_DEC_EN
      intf.dec    = ($urandom_range(0, 2) == 0);
`endif
      intf.wr_sel = 2'($urandom_range(0, 3));
      intf.bus    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      intf.enable = 1'b1;
      intf.rd_sel = 2'($urandom_range(0, 3));
      #1;
      check($sformatf("rnd%0d_data", k), 32'(bus_out),   32'(exp_rd(int'(intf.rd_sel))));
      check($sformatf("rnd%0d_zero", k), 32'(intf.zero), 32'(exp_rd(int'(intf.rd_sel)) == 0));
      do_cycle();
      check($sformatf("rnd%0d_carry", k), 32'(intf.carry), 32'(m_carry));
    end
    set_idle();
    for (int r = 0; r < NREGS; r++) check_read($sformatf("end_reg%0d", r), r);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
